canvas_store: RTL and testbench
===============================

// Module: canvas_store
// PURPOSE
//  32x32 1-bit drawing canvas. Owns pixel storage, takes pen writes, and answers the recognizer's
//  canvas read port (read_enable/read_addr/read_data) combinationally. Sequences submit: pulses
//  rec_start, locks drawing until rec_pending drops. Serves display row reads; tracks set-pixel count.
// PARAMETERS
//  LOCK_TIMEOUT  2047  max cycles in LOCK before forced release (11-bit counter)
// PORTS
//  clk            in   1   system clock; all state on posedge
//  rst            in   1   synchronous, active-high reset
//  draw_en        in   1   pen write strobe, one pixel (or brush) per cycle
//  draw_x         in   5   pen column
//  draw_y         in   5   pen row
//  draw_val       in   1   1=ink, 0=erase
//  clear_req      in   1   request full-canvas clear
//  submit_req     in   1   request recognition
//  rec_start      out  1   one-cycle start pulse to recognizer (its in_start)
//  rec_pending    in   1   recognizer busy flag
//  read_enable    in   1   recognizer read qualifier
//  read_addr      in   10  {row[9:5], col[4:0]}
//  read_data      out  1   canvas[row][col] when read_enable, else 0; combinational, same cycle
//  disp_row       in   5   display row select
//  disp_data      out  32  row disp_row, registered, 1-cycle latency; bit i = column i
//  busy           out  1   state != IDLE
//  pixel_count    out  11  number of set pixels, 0..1024
//  draw_dropped   out  1   one-cycle pulse: draw_en arrived while not IDLE
//  timeout        out  1   one-cycle pulse: LOCK released by timeout
// BEHAVIOUR
//  States: IDLE, CLEAR, START, LOCK. Reset -> CLEAR, row 0; all outputs 0 except busy=1.
//  CLEAR: zero row clr_row each cycle, clr_row++; after row 31 -> IDLE, pixel_count=0. 32 cycles.
//  IDLE: clear_req -> CLEAR (wins over submit_req same cycle, submit dropped);
//        else submit_req -> START; else draw_en writes pixel, pixel_count updated same edge.
//  START: rec_start=1 for exactly one cycle -> LOCK, timer=0.
//  LOCK: rec_pending==0 sampled -> IDLE; timer==LOCK_TIMEOUT -> IDLE, timeout pulse.
//  clear_req/submit_req outside IDLE ignored (not queued). draw_en outside IDLE: no write, draw_dropped=1.
//  pixel_count: +1 per 0->1 bit, -1 per 1->0 bit written; rewriting same value: no change.
//  read_data served in every state (no write races: writes only in IDLE/CLEAR, no recognizer reads then).
//  disp_data reflects canvas state as of the preceding edge (read-before-write on same-cycle draw).
//  rst mid-LOCK/CLEAR: abort, rec_start=0, restart CLEAR at row 0.
// CONFIGURATION
//  CANVAS_BRUSH3_EN defined: draw writes 3x3 square centred at (draw_x,draw_y), clipped at edges
//    (no wrap); pixel_count adds popcount of changed bits over the up-to-3 rows.
//  Undefined: single-pixel writes only.
// STRUCTURE
//  canvas_pkg: CANVAS_W=32, CANVAS_H=32, ADDR_W=10, CNT_W=11, state enum canvas_state_t.
//  Sub-module canvas_brush_mask: (x,y,val,3 old rows) -> 3 new rows + signed count delta;
//    single-pixel mode ties it to one-hot row mask.
// TESTING
//  rst 1 cycle -> busy=1 for 32 cycles, then IDLE, pixel_count=0, all read_data=0.
//  draw (3,2,1) -> read_addr=10'd67 read_data=1; pixel_count=1; redraw same -> stays 1.
//  submit_req -> rec_start high exactly 1 cycle; rec_pending held 1 -> draw_dropped, no write;
//    drop rec_pending -> IDLE next cycle.
//  submit, rec_pending stuck 1 -> timeout pulse after 2047 LOCK cycles, busy=0.
//  clear_req+submit_req same cycle -> CLEAR, no rec_start; pixel_count=0 after 32 cycles.
//  CANVAS_BRUSH3_EN: draw (0,0,1) -> 4 pixels set, no wrap to row/col 31; pixel_count=4.

Source files
------------

// File: rtl/canvas_pkg.sv
// Shared types and constants for the 32x32 drawing canvas.
// Nothing in this file depends on the optional brush feature (CANVAS_BRUSH3_EN).
package canvas_pkg;

  localparam int CANVAS_W = 32;
  localparam int CANVAS_H = 32;
  localparam int ADDR_W   = 10;  // {row[9:5], col[4:0]}
  localparam int CNT_W    = 11;  // set-pixel count, 0..1024
  localparam int TIMER_W  = 11;  // lock watchdog counter
  localparam int DELTA_W  = 7;   // signed per-draw pixel count change

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_START,
    ST_LOCK
  } canvas_state_t;

  // Number of set bits in one canvas row.
  function automatic logic [5:0] popcount_row(input logic [CANVAS_W-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < CANVAS_W; i++) n = n + {5'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/canvas_brush_mask.sv
// Computes the new contents of the three rows around the pen (y-1, y, y+1)
// and the signed change in set-pixel count caused by the write.
// Row index 0 is y-1, 1 is y, 2 is y+1; row_we_o marks rows that really exist.
// CANVAS_BRUSH3_EN defined: 3x3 square brush clipped at the canvas edges.
// CANVAS_BRUSH3_EN undefined: single pixel at (x, y).
module canvas_brush_mask
  import canvas_pkg::*;
(
  input  logic [4:0]                 x_i,
  input  logic [4:0]                 y_i,
  input  logic                       val_i,
  input  logic [2:0][CANVAS_W-1:0]   old_rows_i,
  output logic [2:0][CANVAS_W-1:0]   new_rows_o,
  output logic [2:0]                 row_we_o,
  output logic signed [DELTA_W-1:0]  delta_o
);

`ifdef CANVAS_BRUSH3_EN
  localparam logic BRUSH_EN = 1'b1;
`else
  localparam logic BRUSH_EN = 1'b0;
`endif

  logic [CANVAS_W-1:0] col_mask;
  logic [5:0]          changed;

  // Build column mask and row enables, then merge ink/erase and count flipped bits.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so no latch is inferred.
    col_mask   = 32'd1 << x_i;
    row_we_o   = 3'b010;
    new_rows_o = old_rows_i;
    changed    = '0;
    if (BRUSH_EN) begin
      if (x_i != 5'd0)  col_mask = col_mask | (32'd1 << (x_i - 5'd1));
      if (x_i != 5'd31) col_mask = col_mask | (32'd1 << (x_i + 5'd1));
      row_we_o[0] = (y_i != 5'd0);
      row_we_o[2] = (y_i != 5'd31);
    end
    for (int k = 0; k < 3; k++) begin
      if (row_we_o[k]) begin
        new_rows_o[k] = val_i ? (old_rows_i[k] | col_mask) : (old_rows_i[k] & ~col_mask);
      end
      changed = changed + popcount_row(old_rows_i[k] ^ new_rows_o[k]);
    end
    delta_o = val_i ? $signed({1'b0, changed}) : -$signed({1'b0, changed});
  end

endmodule

// File: rtl/canvas_store.sv
// 32x32 1-bit drawing canvas: pixel storage, pen writes, recognizer read port,
// submit sequencing with lock/watchdog, registered display row reads and a
// running set-pixel count.
// Optional feature macro: CANVAS_BRUSH3_EN (3x3 brush instead of single pixel).
module canvas_store
  import canvas_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 2047
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                draw_en,
  input  logic [4:0]          draw_x,
  input  logic [4:0]          draw_y,
  input  logic                draw_val,
  input  logic                clear_req,
  input  logic                submit_req,
  output logic                rec_start,
  input  logic                rec_pending,
  input  logic                read_enable,
  input  logic [ADDR_W-1:0]   read_addr,
  output logic                read_data,
  input  logic [4:0]          disp_row,
  output logic [CANVAS_W-1:0] disp_data,
  output logic                busy,
  output logic [CNT_W-1:0]    pixel_count,
  output logic                draw_dropped,
  output logic                timeout
);

  canvas_state_t         state_q;
  logic [4:0]            clr_row_q;
  logic [TIMER_W-1:0]    timer_q;
  logic                  rec_start_q;
  logic                  draw_dropped_q;
  logic                  timeout_q;
  logic [CNT_W-1:0]      pixel_count_q;
  logic [CNT_W-1:0]      pixel_count_d;
  logic [CANVAS_W-1:0]   disp_data_q;
  logic [CANVAS_W-1:0]   canvas_q [CANVAS_H];

  logic [2:0][4:0]          row_idx;
  logic [2:0][CANVAS_W-1:0] old_rows;
  logic [2:0][CANVAS_W-1:0] new_rows;
  logic [2:0]               row_we;
  logic signed [DELTA_W-1:0] delta;
  logic                     draw_go;

  // Rows above/below the pen wrap here, but row_we suppresses any wrapped row.
  assign row_idx[0] = draw_y - 5'd1;
  assign row_idx[1] = draw_y;
  assign row_idx[2] = draw_y + 5'd1;
  assign old_rows[0] = canvas_q[row_idx[0]];
  assign old_rows[1] = canvas_q[row_idx[1]];
  assign old_rows[2] = canvas_q[row_idx[2]];

  canvas_brush_mask u_brush (
    .x_i        (draw_x),
    .y_i        (draw_y),
    .val_i      (draw_val),
    .old_rows_i (old_rows),
    .new_rows_o (new_rows),
    .row_we_o   (row_we),
    .delta_o    (delta)
  );

  // Clear and submit both take priority over a pen write in IDLE.
  assign draw_go = !rst && (state_q == ST_IDLE) && draw_en && !clear_req && !submit_req;
  assign pixel_count_d = pixel_count_q + {{(CNT_W-DELTA_W){delta[DELTA_W-1]}}, delta};

  // Pixel storage: row sweep in CLEAR, pen writes in IDLE.
  // NOTE: the array has no reset term; the CLEAR sweep that follows every reset zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        canvas_q[clr_row_q] <= '0;
      end else if (draw_go) begin
        for (int k = 0; k < 3; k++) begin
          if (row_we[k]) canvas_q[row_idx[k]] <= new_rows[k];
        end
      end
    end
  end

  // Control FSM with registered pulses, pixel counter and display row register.
  // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_CLEAR;
      clr_row_q      <= '0;
      timer_q        <= '0;
      rec_start_q    <= 1'b0;
      draw_dropped_q <= 1'b0;
      timeout_q      <= 1'b0;
      pixel_count_q  <= '0;
      disp_data_q    <= '0;
    end else begin
      rec_start_q    <= 1'b0;
      timeout_q      <= 1'b0;
      draw_dropped_q <= draw_en && (state_q != ST_IDLE);
      disp_data_q    <= canvas_q[disp_row];
      case (state_q)
        ST_CLEAR: begin
          clr_row_q <= clr_row_q + 5'd1;
          if (clr_row_q == 5'd31) begin
            state_q       <= ST_IDLE;
            pixel_count_q <= '0;
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            state_q   <= ST_CLEAR;
            clr_row_q <= '0;
          end else if (submit_req) begin
            state_q     <= ST_START;
            rec_start_q <= 1'b1;
          end else if (draw_en) begin
            pixel_count_q <= pixel_count_d;
          end
        end
        ST_START: begin
          state_q <= ST_LOCK;
          timer_q <= '0;
        end
        ST_LOCK: begin
          if (!rec_pending) begin
            state_q <= ST_IDLE;
          end else if (timer_q == TIMER_W'(LOCK_TIMEOUT)) begin
            state_q   <= ST_IDLE;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign read_data    = read_enable ? canvas_q[read_addr[9:5]][read_addr[4:0]] : 1'b0;
  assign rec_start    = rec_start_q;
  assign busy         = (state_q != ST_IDLE);
  assign pixel_count  = pixel_count_q;
  assign draw_dropped = draw_dropped_q;
  assign timeout      = timeout_q;
  assign disp_data    = disp_data_q;

endmodule

// File: tb/tb_canvas_store.sv
// Self-checking bench for canvas_store: reference canvas model, scoreboard
// queue for display reads, directed submit/lock/timeout/clear/reset scenarios.
// Build with CANVAS_BRUSH3_EN defined to exercise the 3x3 brush.
module tb_canvas_store;

`ifdef CANVAS_BRUSH3_EN
  localparam int BR = 1;
`else
  localparam int BR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        draw_en;
  logic [4:0]  draw_x;
  logic [4:0]  draw_y;
  logic        draw_val;
  logic        clear_req;
  logic        submit_req;
  logic        rec_start;
  logic        rec_pending;
  logic        read_enable;
  logic [9:0]  read_addr;
  logic        read_data;
  logic [4:0]  disp_row;
  logic [31:0] disp_data;
  logic        busy;
  logic [10:0] pixel_count;
  logic        draw_dropped;
  logic        timeout;

  always #5 clk = ~clk;

  canvas_store #(.LOCK_TIMEOUT(2047)) dut (
    .clk          (clk),
    .rst          (rst),
    .draw_en      (draw_en),
    .draw_x       (draw_x),
    .draw_y       (draw_y),
    .draw_val     (draw_val),
    .clear_req    (clear_req),
    .submit_req   (submit_req),
    .rec_start    (rec_start),
    .rec_pending  (rec_pending),
    .read_enable  (read_enable),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .disp_row     (disp_row),
    .disp_data    (disp_data),
    .busy         (busy),
    .pixel_count  (pixel_count),
    .draw_dropped (draw_dropped),
    .timeout      (timeout)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model [32];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_count();
    int n = 0;
    for (int r = 0; r < 32; r++) n += $countones(model[r]);
    return n;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) model[r] = '0;
  endtask

  task automatic model_draw(input int x, input int y, input logic v);
    for (int dy = -BR; dy <= BR; dy++) begin
      for (int dx = -BR; dx <= BR; dx++) begin
        int yy;
        int xx;
        yy = y + dy;
        xx = x + dx;
        if (yy >= 0 && yy < 32 && xx >= 0 && xx < 32) model[yy][xx] = v;
      end
    end
  endtask

  task automatic peek(input int x, input int y, output logic d);
    read_enable = 1'b1;
    read_addr   = {y[4:0], x[4:0]};
    #1;
    d = read_data;
    read_enable = 1'b0;
  endtask

  task automatic scan(input string tag);
    int   bad = 0;
    logic d;
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 32; x++) begin
        peek(x, y, d);
        if (d !== model[y][x]) bad++;
      end
    end
    check(tag, bad, 0);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
    end else begin
      check(tag, got, exp_q.pop_front());
    end
  endtask

  // Draw one pixel/brush; display the same row in the same cycle (read-before-write).
  task automatic do_draw(input int x, input int y, input logic v);
    draw_x   = x[4:0];
    draw_y   = y[4:0];
    draw_val = v;
    draw_en  = 1'b1;
    disp_row = y[4:0];
    exp_q.push_back(model[y]);
    model_draw(x, y, v);
    tick();
    draw_en = 1'b0;
    pop_check("disp_rbw", disp_data);
    check("pix_cnt", pixel_count, model_count());
  endtask

  task automatic disp_read(input int row);
    disp_row = row[4:0];
    exp_q.push_back(model[row]);
    tick();
    pop_check("disp_row", disp_data);
  endtask

  task automatic wait_idle(input string tag, input int exp_cycles);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check(tag, n, exp_cycles);
  endtask

  initial begin
    logic d;
    int   n;
    logic seen;

    rst = 1'b1; draw_en = 1'b0; draw_x = '0; draw_y = '0; draw_val = 1'b0;
    clear_req = 1'b0; submit_req = 1'b0; rec_pending = 1'b0;
    read_enable = 1'b0; read_addr = '0; disp_row = '0;
    model_clear();

    // Reset: CLEAR for 32 cycles, every output low except busy.
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 1);
    check("rst_rec_start", rec_start, 0);
    check("rst_pix_cnt", pixel_count, 0);
    check("rst_dropped", draw_dropped, 0);
    check("rst_timeout", timeout, 0);
    check("rst_disp", disp_data, 0);
    wait_idle("rst_clear_cycles", 32);
    check("rst_pix_cnt_idle", pixel_count, 0);
    scan("scan_after_reset");
    tick();

    // Pen writes.
    do_draw(3, 2, 1'b1);
    read_enable = 1'b1; read_addr = 10'd67; #1;
    check("rd_addr67", read_data, 1);
    read_enable = 1'b0; #1;
    check("rd_gated", read_data, 0);
    do_draw(3, 2, 1'b1);
    do_draw(31, 31, 1'b1);
    do_draw(15, 0, 1'b1);
    do_draw(20, 17, 1'b1);
    do_draw(4, 2, 1'b0);
    disp_read(2);
    disp_read(31);
    disp_read(17);
    disp_read(0);
    scan("scan_after_draws");
    tick();

    // Submit: one-cycle rec_start, locked drawing, ignored clear, release on rec_pending low.
    rec_pending = 1'b1;
    submit_req  = 1'b1;
    tick();
    submit_req = 1'b0;
    check("sub_rec_start", rec_start, 1);
    check("sub_busy", busy, 1);
    tick();
    check("sub_rec_start_1cyc", rec_start, 0);
    draw_x = 5'd10; draw_y = 5'd10; draw_val = 1'b1; draw_en = 1'b1;
    tick();
    draw_en = 1'b0;
    check("lock_draw_dropped", draw_dropped, 1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("lock_dropped_pulse", draw_dropped, 0);
    check("lock_busy", busy, 1);
    rec_pending = 1'b0;
    tick();
    check("lock_release", busy, 0);
    tick();
    check("lock_clear_not_queued", busy, 0);
    check("lock_pix_cnt", pixel_count, model_count());
    scan("scan_after_lock");
    tick();

    // Watchdog: rec_pending stuck high.
    rec_pending = 1'b1;
    submit_req  = 1'b1;
    tick();
    submit_req = 1'b0;
    n = 0;
    while (!timeout && n < 3000) begin
      tick();
      n++;
    end
    check("timeout_seen", timeout, 1);
    check("timeout_latency_window", (n >= 2047 && n <= 2050), 1);
    check("timeout_busy", busy, 0);
    tick();
    check("timeout_pulse", timeout, 0);
    rec_pending = 1'b0;

    // clear_req and submit_req together: clear wins, no start pulse.
    check("pre_clear_nonzero", (pixel_count != 0), 1);
    rec_pending = 1'b1;
    clear_req   = 1'b1;
    submit_req  = 1'b1;
    tick();
    clear_req  = 1'b0;
    submit_req = 1'b0;
    n = 0;
    seen = 1'b0;
    while (busy && n < 200) begin
      seen = seen | rec_start;
      tick();
      n++;
    end
    rec_pending = 1'b0;
    check("clr_sub_cycles", n, 32);
    check("clr_sub_no_start", seen, 0);
    check("clr_pix_cnt", pixel_count, 0);
    model_clear();
    scan("scan_after_clear");
    tick();

    // Corner draws: brush clips at the edges, never wraps.
    do_draw(0, 0, 1'b1);
`ifdef CANVAS_BRUSH3_EN
    check("brush_corner_cnt", pixel_count, 4);
`else
    check("pixel_corner_cnt", pixel_count, 1);
`endif
    peek(31, 0, d);  check("no_wrap_col31", d, 0);
    peek(0, 31, d);  check("no_wrap_row31", d, 0);
    peek(31, 31, d); check("no_wrap_corner", d, 0);
    do_draw(31, 31, 1'b1);
    do_draw(16, 31, 1'b1);
    scan("scan_corners");
    tick();

    // Reset while START is active: pulse dies, CLEAR restarts from row 0.
    rec_pending = 1'b1;
    submit_req  = 1'b1;
    tick();
    submit_req = 1'b0;
    check("rst2_start", rec_start, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_rec_start", rec_start, 0);
    check("rst2_busy", busy, 1);
    wait_idle("rst2_clear_cycles", 32);
    rec_pending = 1'b0;
    check("rst2_pix_cnt", pixel_count, 0);
    model_clear();
    scan("scan_after_rst2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
